// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, operand-lookup and commit signals of the reorder buffer.
// The master side is the core pipeline; the slave side is the buffer itself.
interface reorder_buffer_if #(
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int RF_ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH     = 32
);
    logic                      alloc_en;
    logic                      alloc_reg_write;
    logic [RF_ADDR_WIDTH-1:0]  alloc_dest;
    logic [31:0]               alloc_pc;
    logic                      alloc_ready;
    logic [ROB_ADDR_WIDTH-1:0] alloc_id;

    logic                      wb_en;
    logic [ROB_ADDR_WIDTH-1:0] wb_id;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      wb_exception;

    logic [ROB_ADDR_WIDTH-1:0] read_id_1;
    logic [ROB_ADDR_WIDTH-1:0] read_id_2;
    logic                      read_ready_1;
    logic                      read_ready_2;
    logic [DATA_WIDTH-1:0]     read_data_1;
    logic [DATA_WIDTH-1:0]     read_data_2;

    logic                      commit_en;
    logic [RF_ADDR_WIDTH-1:0]  commit_addr;
    logic [DATA_WIDTH-1:0]     commit_data;
    logic                      commit_restore;
    logic [31:0]               commit_pc;

    logic                      empty;
    logic                      full;

    modport master (
        output alloc_en, alloc_reg_write, alloc_dest, alloc_pc,
        output wb_en, wb_id, wb_data, wb_exception,
        output read_id_1, read_id_2,
        input  alloc_ready, alloc_id,
        input  read_ready_1, read_ready_2, read_data_1, read_data_2,
        input  commit_en, commit_addr, commit_data, commit_restore, commit_pc,
        input  empty, full
    );

    modport slave (
        input  alloc_en, alloc_reg_write, alloc_dest, alloc_pc,
        input  wb_en, wb_id, wb_data, wb_exception,
        input  read_id_1, read_id_2,
        output alloc_ready, alloc_id,
        output read_ready_1, read_ready_2, read_data_1, read_data_2,
        output commit_en, commit_addr, commit_data, commit_restore, commit_pc,
        output empty, full
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename ids, captures writeback results and
// retires in program order into the register file, flushing on an excepting head.
module reorder_buffer #(
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int RF_ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  rob
);
    localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
    localparam logic [ROB_ADDR_WIDTH:0] FULL_CNT = {1'b1, {ROB_ADDR_WIDTH{1'b0}}};

    logic [DEPTH-1:0]          valid_q;
    logic [DEPTH-1:0]          done_q;
    logic [DEPTH-1:0]          exc_q;
    logic                      reg_write_q [DEPTH];
    logic [RF_ADDR_WIDTH-1:0]  dest_q      [DEPTH];
    logic [31:0]               pc_q        [DEPTH];
    logic [DATA_WIDTH-1:0]     data_q      [DEPTH];

    logic [ROB_ADDR_WIDTH-1:0] head;
    logic [ROB_ADDR_WIDTH-1:0] tail;
    logic [ROB_ADDR_WIDTH:0]   count;

    logic                      commit_en_q;
    logic [RF_ADDR_WIDTH-1:0]  commit_addr_q;
    logic [DATA_WIDTH-1:0]     commit_data_q;
    logic                      commit_restore_q;
    logic [31:0]               commit_pc_q;

    logic full_w;
    logic alloc_ready_w;
    logic do_alloc;
    logic head_done;
    logic retire_ok;
    logic flush;
    logic wb_hit;

    assign full_w        = (count == FULL_CNT);
    assign alloc_ready_w = !full_w && !commit_restore_q;
    assign do_alloc      = rob.alloc_en && alloc_ready_w;
    // Retirement looks only at registered state, so a same-cycle writeback never retires
    assign head_done     = valid_q[head] && done_q[head];
    assign retire_ok     = head_done && !exc_q[head];
    assign flush         = head_done && exc_q[head];
    assign wb_hit        = rob.wb_en && valid_q[rob.wb_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            done_q           <= '0;
            exc_q            <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            commit_en_q      <= 1'b0;
            commit_addr_q    <= '0;
            commit_data_q    <= '0;
            commit_restore_q <= 1'b0;
            commit_pc_q      <= '0;
        end else begin
            commit_en_q      <= 1'b0;
            commit_addr_q    <= '0;
            commit_data_q    <= '0;
            commit_restore_q <= 1'b0;
            commit_pc_q      <= '0;
            if (flush) begin
                valid_q          <= '0;
                done_q           <= '0;
                exc_q            <= '0;
                head             <= '0;
                tail             <= '0;
                count            <= '0;
                commit_restore_q <= 1'b1;
                commit_pc_q      <= pc_q[head];
            end else begin
                if (wb_hit) begin
                    done_q[rob.wb_id] <= 1'b1;
                    exc_q[rob.wb_id]  <= rob.wb_exception;
                end
                if (do_alloc) begin
                    valid_q[tail] <= 1'b1;
                    done_q[tail]  <= 1'b0;
                    exc_q[tail]   <= 1'b0;
                    tail          <= tail + 1'b1;
                end
                // Clearing the head is ordered after writeback so retirement wins
                if (retire_ok) begin
                    valid_q[head] <= 1'b0;
                    done_q[head]  <= 1'b0;
                    exc_q[head]   <= 1'b0;
                    head          <= head + 1'b1;
                    commit_en_q   <= reg_write_q[head];
                    commit_addr_q <= dest_q[head];
                    commit_data_q <= data_q[head];
                    commit_pc_q   <= pc_q[head];
                end
                case ({do_alloc, retire_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage carries no reset; the valid/done bits qualify every read
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            reg_write_q[tail] <= rob.alloc_reg_write;
            dest_q[tail]      <= rob.alloc_dest;
            pc_q[tail]        <= rob.alloc_pc;
        end
        if (wb_hit) begin
            data_q[rob.wb_id] <= rob.wb_data;
        end
    end

    assign rob.read_ready_1 = valid_q[rob.read_id_1] &&
                              (done_q[rob.read_id_1] || (rob.wb_en && rob.wb_id == rob.read_id_1));
    assign rob.read_data_1  = !valid_q[rob.read_id_1]                 ? '0 :
                              (rob.wb_en && rob.wb_id == rob.read_id_1) ? rob.wb_data :
                              done_q[rob.read_id_1]                    ? data_q[rob.read_id_1] : '0;
    assign rob.read_ready_2 = valid_q[rob.read_id_2] &&
                              (done_q[rob.read_id_2] || (rob.wb_en && rob.wb_id == rob.read_id_2));
    assign rob.read_data_2  = !valid_q[rob.read_id_2]                 ? '0 :
                              (rob.wb_en && rob.wb_id == rob.read_id_2) ? rob.wb_data :
                              done_q[rob.read_id_2]                    ? data_q[rob.read_id_2] : '0;

    assign rob.alloc_ready    = alloc_ready_w;
    assign rob.alloc_id       = tail;
    assign rob.empty          = (count == '0);
    assign rob.full           = full_w;
    assign rob.commit_en      = commit_en_q;
    assign rob.commit_addr    = commit_addr_q;
    assign rob.commit_data    = commit_data_q;
    assign rob.commit_restore = commit_restore_q;
    assign rob.commit_pc      = commit_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    reorder_buffer_if #(.ROB_ADDR_WIDTH(4), .RF_ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    reorder_buffer #(.ROB_ADDR_WIDTH(4), .RF_ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .rob (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          rw;
        logic [5:0]  dest;
        logic [31:0] pc;
        bit          done;
        bit          exc;
        logic [31:0] data;
    } ent_t;

    // Model: in-flight instructions in program order, oldest first
    ent_t        q[$];
    int          m_tail = 0;
    bit          e_en = 0;
    bit          e_rst = 0;
    logic [5:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic [31:0] e_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void look(input logic [3:0] id, output bit rdy, output logic [31:0] d);
        rdy = 0;
        d   = '0;
        foreach (q[i]) begin
            if (q[i].id == int'(id)) begin
                if (bus.wb_en && bus.wb_id == id) begin
                    rdy = 1;
                    d   = bus.wb_data;
                end else if (q[i].done) begin
                    rdy = 1;
                    d   = q[i].data;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_tail = 0;
            e_en = 0; e_rst = 0; e_addr = '0; e_data = '0; e_pc = '0;
        end else begin
            bit   acc;
            bit   ret;
            bit   fl;
            ent_t h;
            ent_t n;
            acc = bus.alloc_en && (q.size() < 16) && !e_rst;
            ret = 0;
            fl  = 0;
            if (q.size() > 0 && q[0].done) begin
                h = q[0];
                if (h.exc) fl = 1;
                else       ret = 1;
            end
            e_en = 0; e_rst = 0; e_addr = '0; e_data = '0; e_pc = '0;
            if (fl) begin
                q.delete();
                m_tail = 0;
                e_rst  = 1;
                e_pc   = h.pc;
            end else begin
                if (bus.wb_en) begin
                    foreach (q[i]) begin
                        if (q[i].id == int'(bus.wb_id)) begin
                            q[i].done = 1;
                            q[i].exc  = bus.wb_exception;
                            q[i].data = bus.wb_data;
                        end
                    end
                end
                if (ret) begin
                    void'(q.pop_front());
                    e_en   = h.rw;
                    e_addr = h.dest;
                    e_data = h.data;
                    e_pc   = h.pc;
                end
                if (acc) begin
                    n.id   = m_tail;
                    n.rw   = bus.alloc_reg_write;
                    n.dest = bus.alloc_dest;
                    n.pc   = bus.alloc_pc;
                    n.done = 0;
                    n.exc  = 0;
                    n.data = '0;
                    q.push_back(n);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit          r;
        logic [31:0] d;
        chk("alloc_ready", bus.alloc_ready, (q.size() < 16) && !e_rst);
        chk("alloc_id", bus.alloc_id, m_tail);
        chk("empty", bus.empty, q.size() == 0);
        chk("full", bus.full, q.size() == 16);
        chk("commit_en", bus.commit_en, e_en);
        chk("commit_addr", bus.commit_addr, e_addr);
        chk("commit_data", bus.commit_data, e_data);
        chk("commit_restore", bus.commit_restore, e_rst);
        chk("commit_pc", bus.commit_pc, e_pc);
        look(bus.read_id_1, r, d);
        chk("read_ready_1", bus.read_ready_1, r);
        chk("read_data_1", bus.read_data_1, d);
        look(bus.read_id_2, r, d);
        chk("read_ready_2", bus.read_ready_2, r);
        chk("read_data_2", bus.read_data_2, d);
    end

    task automatic idle();
        bus.alloc_en = 0; bus.alloc_reg_write = 0; bus.alloc_dest = '0; bus.alloc_pc = '0;
        bus.wb_en = 0; bus.wb_id = '0; bus.wb_data = '0; bus.wb_exception = 0;
        bus.read_id_1 = '0; bus.read_id_2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic alloc(input logic rw, input logic [5:0] dest, input logic [31:0] pc);
        bus.alloc_en = 1; bus.alloc_reg_write = rw; bus.alloc_dest = dest; bus.alloc_pc = pc;
    endtask

    task automatic wb(input logic [3:0] id, input logic [31:0] data, input logic exc);
        bus.wb_en = 1; bus.wb_id = id; bus.wb_data = data; bus.wb_exception = exc;
    endtask

    initial begin
        idle();
        do_reset();
        // Reset state
        chk("rst_empty", bus.empty, 1);
        chk("rst_alloc_id", bus.alloc_id, 0);
        chk("rst_alloc_ready", bus.alloc_ready, 1);
        chk("rst_commit_en", bus.commit_en, 0);
        chk("rst_commit_restore", bus.commit_restore, 0);
        chk("rst_commit_data", bus.commit_data, 0);
        chk("rst_commit_pc", bus.commit_pc, 0);

        // Single alloc -> wb -> commit
        alloc(1, 6'd1, 32'h100);
        chk("t2_alloc_id", bus.alloc_id, 0);
        step();
        idle();
        wb(4'd0, 32'h12345678, 0);
        step();
        idle();
        step();
        chk("t2_commit_en", bus.commit_en, 1);
        chk("t2_commit_addr", bus.commit_addr, 1);
        chk("t2_commit_data", bus.commit_data, 32'h12345678);
        chk("t2_commit_pc", bus.commit_pc, 32'h100);
        chk("t2_empty", bus.empty, 1);
        step();
        chk("t2_commit_en_drop", bus.commit_en, 0);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(1, 6'd2, 32'h200); step();
        alloc(1, 6'd3, 32'h204); step();
        idle(); wb(4'd1, 32'habcdef00, 0); step();
        idle(); wb(4'd0, 32'h11, 0); step();
        chk("t3_no_early_commit", bus.commit_en, 0);
        idle(); step();
        chk("t3_c0_en", bus.commit_en, 1);
        chk("t3_c0_addr", bus.commit_addr, 2);
        chk("t3_c0_data", bus.commit_data, 32'h11);
        step();
        chk("t3_c1_en", bus.commit_en, 1);
        chk("t3_c1_addr", bus.commit_addr, 3);
        chk("t3_c1_data", bus.commit_data, 32'habcdef00);
        step();
        chk("t3_empty", bus.empty, 1);

        // Fill to 16, overflow ignored, wrap on retire
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(1, 6'(i + 8), 32'h1000 + 32'(i * 4));
            chk("t4_alloc_id", bus.alloc_id, i);
            step();
        end
        chk("t4_full", bus.full, 1);
        chk("t4_alloc_ready", bus.alloc_ready, 0);
        chk("t4_alloc_id_wrap", bus.alloc_id, 0);
        step();
        chk("t4_still_full", bus.full, 1);
        wb(4'd0, 32'h55, 0); step();
        bus.wb_en = 0; step();
        chk("t4_retire_en", bus.commit_en, 1);
        chk("t4_retire_addr", bus.commit_addr, 8);
        chk("t4_not_full", bus.full, 0);
        chk("t4_ready_again", bus.alloc_ready, 1);
        chk("t4_alloc_id_0", bus.alloc_id, 0);
        step();
        chk("t4_refull", bus.full, 1);
        chk("t4_alloc_id_1", bus.alloc_id, 1);
        idle();

        // Exception at head flushes everything
        do_reset();
        alloc(1, 6'd5, 32'h200); step();
        alloc(1, 6'd6, 32'h204); step();
        idle(); wb(4'd0, 32'hdead, 1); step();
        idle(); alloc(1, 6'd7, 32'h208); step();
        chk("t5_restore", bus.commit_restore, 1);
        chk("t5_commit_en", bus.commit_en, 0);
        chk("t5_commit_pc", bus.commit_pc, 32'h200);
        chk("t5_ready_low", bus.alloc_ready, 0);
        chk("t5_empty_pulse", bus.empty, 1);
        chk("t5_alloc_id_pulse", bus.alloc_id, 0);
        step();
        idle();
        chk("t5_restore_drop", bus.commit_restore, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_alloc_id", bus.alloc_id, 0);

        // Writeback bypass on lookup, and lookup of an unallocated id
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(0, 6'(i), 32'(i)); step();
        end
        idle();
        bus.read_id_1 = 4'd5; bus.read_id_2 = 4'd9;
        wb(4'd5, 32'h10203040, 0);
        #1;
        chk("t6_bypass_ready", bus.read_ready_1, 1);
        chk("t6_bypass_data", bus.read_data_1, 32'h10203040);
        chk("t6_unalloc_ready", bus.read_ready_2, 0);
        chk("t6_unalloc_data", bus.read_data_2, 0);
        step();
        idle();

        // Randomized traffic with occasional mid-run reset
        for (int c = 0; c < 4000; c++) begin
            bus.alloc_en        = ($urandom_range(0, 99) < 55);
            bus.alloc_reg_write = $urandom_range(0, 1);
            bus.alloc_dest      = 6'($urandom);
            bus.alloc_pc        = $urandom;
            bus.wb_en           = ($urandom_range(0, 99) < 60);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                bus.wb_id = 4'(q[$urandom_range(0, q.size() - 1)].id);
            else
                bus.wb_id = 4'($urandom);
            bus.wb_data      = $urandom;
            bus.wb_exception = ($urandom_range(0, 39) == 0);
            bus.read_id_1    = 4'($urandom);
            bus.read_id_2    = (q.size() > 0) ? 4'(q[0].id) : 4'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                rst = 0;
                #1;
                rst = 1;
            end
            step();
        end
        idle();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
